display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Sequencer for the 8-digit seven-segment nibble display path.
- Owns the digit scan index, the per-digit refresh timing, the active-low anode enables and an anti-ghosting guard interval.
- Double-buffers the 32-bit display value so a new value is applied only at a frame boundary, which prevents tearing.
- Feeds the nibble-to-segment decoder and drives the board anodes.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit is driven (DRIVE phase length), minimum 2.
- GUARD_CYC, 4, clk cycles all anodes are off between digits (GUARD phase length), minimum 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  scan enable; low forces IDLE.
- load  input  1  single-cycle strobe; capture din.
- din  input  32  display value; digit i = din[4i+3:4i].
- blank_lz  input  1  enable leading-zero blanking.
- anode  output  8  active-low digit enables, one-hot-low or all ones.
- digit_sel  output  3  current digit index.
- nibble  output  4  active[4*digit_sel+3 : 4*digit_sel].
- pending  output  1  shadow holds a value not yet applied.
- frame_done  output  1  one-cycle pulse when digit wraps 7->0.

Behaviour:
- Interface is decided: one clock `clk`; reset `rst` is synchronous and active-high.

Reset (rst=1 at an edge; wins over all other inputs):
- state=IDLE, anode=8'hFF, digit_sel=0, nibble=0.
- pending=0, frame_done=0, active=0, shadow=0.
- Prescaler and guard counter cleared.

Registers:
- shadow[31:0], active[31:0], pending, 2-bit state, prescaler (clog2(REFRESH_DIV) bits), guard counter, digit_sel.

Output timing:
- anode, nibble and digit_sel are combinational decodes of registered state, so they have zero additional latency.
- frame_done is registered.

Load handling (any state, including IDLE):
- On load: shadow<=din, pending<=1.

FSM states IDLE / DRIVE / GUARD:
- IDLE: anode=FF; prescaler=0; digit_sel=0.
  - When en=1: go to DRIVE next cycle.
  - If pending at that transition: active<=shadow, pending<=0.
- DRIVE: anode[digit_sel]=0, all other anode bits 1, unless the digit is blanked.
  - Prescaler counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1: go to GUARD and clear prescaler.
- GUARD: anode=FF; guard counter counts 0..GUARD_CYC-1.
  - At terminal count: digit_sel<=digit_sel+1 (mod 8) and go to DRIVE.
- en=0 in DRIVE or GUARD: go to IDLE at the next edge. Counters and digit_sel are cleared and anode=FF from that cycle.

Frame boundary (GUARD terminal count with digit_sel=7):
- frame_done=1 for exactly one cycle, coincident with digit_sel becoming 0.
- If pending: active<=shadow, pending<=0.
- If load arrives in that same cycle: active<=din, shadow<=din, pending<=0 (new data wins).

Leading-zero blanking:
- With blank_lz=1, digit i (i>=1) is blanked if active[31:4i]==0.
- A blanked digit keeps anode=FF during its DRIVE slot; timing is unchanged.
- Digit 0 is never blanked.

Timing:
- Frame period is 8*(REFRESH_DIV+GUARD_CYC) cycles.
- Anode duty per digit is REFRESH_DIV/(REFRESH_DIV+GUARD_CYC).

Invariants:
- At most one anode bit is low at any time.
- No two different anode bits are low on consecutive cycles.

Test Plan:
- Bench uses REFRESH_DIV=4, GUARD_CYC=2, so a frame is 48 cycles.
1. Reset then en=1, no load -> anode FE for 4 cycles, FF for 2, FD for 4, ...; nibble=0 throughout; frame_done pulses every 48 cycles.
2. IDLE load din=32'h8765_4321 then en=1 -> pending clears on the enable edge; nibble sequence 1,2,...,8 with digit_sel 0..7.
3. Mid-frame load 32'hDEAD_BEEF at digit 3 -> pending=1; nibbles continue from the old value through digit 7; new value appears at digit 0 on the frame_done cycle; pending then 0.
4. load asserted exactly on the frame_done cycle with din=32'h0000_00A5 while shadow is pending -> active=0x000000A5 and pending=0 immediately.
5. blank_lz=1, active=32'h0000_0305 -> anode low only in slots 0, 1 and 2 (digit 1 nibble 0 is shown); slots 3..7 keep anode=FF.
6. en dropped during GUARD, and separately rst during DRIVE at digit 5 -> next cycle anode=FF and digit_sel=0; after rst, active=0 and pending=0.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 8-digit seven-segment scan sequencer with guard gaps and frame-synchronous double buffering
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] din,
    input  logic        blank_lz,
    output logic [7:0]  anode,
    output logic [2:0]  digit_sel,
    output logic [3:0]  nibble,
    output logic        pending,
    output logic        frame_done
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int GW = GUARD_CYC > 1 ? $clog2(GUARD_CYC) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYC - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, GUARD} state_t;

    state_t state, state_n;
    logic [31:0] shadow, active;
    logic [PW-1:0] presc;
    logic [GW-1:0] gcnt;
    logic drive_end, guard_end, wrap, apply, blanked;

    always_comb begin
        drive_end = en && state == DRIVE && presc == P_LAST;
        guard_end = en && state == GUARD && gcnt == G_LAST;
        wrap = guard_end && digit_sel == 3'd7;
        apply = (en && state == IDLE) || wrap;
        state_n = !en ? IDLE : state == IDLE ? DRIVE : drive_end ? GUARD : guard_end ? DRIVE : state;
        blanked = blank_lz && digit_sel != 3'd0 && (active >> {digit_sel, 2'b00}) == 32'd0;
        anode = (state == DRIVE && !blanked) ? ~(8'd1 << digit_sel) : 8'hFF;
        nibble = active[{digit_sel, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shadow <= '0;
            active <= '0;
            pending <= 1'b0;
            frame_done <= 1'b0;
            presc <= '0;
            gcnt <= '0;
            digit_sel <= '0;
        end else begin
            state <= state_n;
            frame_done <= wrap;
            presc <= (en && state == DRIVE && !drive_end) ? presc + 1'b1 : '0;
            gcnt <= (en && state == GUARD && !guard_end) ? gcnt + 1'b1 : '0;
            digit_sel <= state_n == IDLE ? 3'd0 : digit_sel + 3'(guard_end);
            shadow <= load ? din : shadow;
            // shadow equals active whenever nothing is pending, so copying unconditionally is safe
            active <= apply ? (load ? din : shadow) : active;
            pending <= apply ? 1'b0 : (load ? 1'b1 : pending);
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed stimulus with a slot-arithmetic reference model checked every cycle
module tb_display_scan_ctrl;
    localparam int RD = 4;
    localparam int GC = 2;
    localparam int SLOT = RD + GC;
    localparam int FRAME = 8 * SLOT;

    logic clk, rst, en, load, blank_lz;
    logic [31:0] din;
    logic [7:0] anode;
    logic [2:0] digit_sel;
    logic [3:0] nibble;
    logic pending, frame_done;

    int checks = 0;
    int errors = 0;

    display_scan_ctrl #(.REFRESH_DIV(RD), .GUARD_CYC(GC)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .din(din), .blank_lz(blank_lz),
        .anode(anode), .digit_sel(digit_sel), .nibble(nibble),
        .pending(pending), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: scanning position is simply elapsed cycles since enable, modulo the frame.
    bit on = 0;
    int t = 0;
    logic [31:0] m_act = 0, m_sh = 0;
    bit m_pend = 0, m_fd = 0, wrap, app, drv, blk;
    int d;
    logic [7:0] e_an, prev_an = 8'hFF;

    always @(posedge clk) begin
        if (rst) begin
            on = 0; t = 0; m_act = 0; m_sh = 0; m_pend = 0; m_fd = 0;
        end else begin
            wrap = on && en && (t % FRAME == FRAME - 1);
            app = (!on && en) || wrap;
            m_fd = wrap;
            if (!en) begin on = 0; t = 0; end
            else if (!on) begin on = 1; t = 0; end
            else t++;
            if (app) begin
                if (load) m_sh = din;
                m_act = m_sh;
                m_pend = 0;
            end else if (load) begin
                m_sh = din;
                m_pend = 1;
            end
        end
        #1;
        d = on ? (t % FRAME) / SLOT : 0;
        drv = on && (t % SLOT) < RD;
        blk = blank_lz && d > 0 && (m_act >> (4 * d)) == 32'd0;
        e_an = (drv && !blk) ? 8'(~(8'd1 << d)) : 8'hFF;
        chk("anode", anode, e_an);
        chk("digit_sel", digit_sel, d);
        chk("nibble", nibble, 4'(m_act >> (4 * d)));
        chk("pending", pending, m_pend);
        chk("frame_done", frame_done, m_fd);
        chk("one_hot_low", $countones(~anode) <= 1, 1);
        chk("no_adjacent_switch", (prev_an != 8'hFF && anode != 8'hFF && prev_an != anode), 0);
        prev_an = anode;
    end

    initial begin
        int n;
        rst = 1; en = 0; load = 0; din = 0; blank_lz = 0;
        repeat (2) @(negedge clk);
        chk("rst_anode", anode, 8'hFF);
        chk("rst_digit", digit_sel, 0);
        chk("rst_nibble", nibble, 0);
        chk("rst_pending", pending, 0);
        chk("rst_fd", frame_done, 0);
        rst = 0;
        @(negedge clk);
        // 1: free-running scan of zero
        en = 1;
        @(negedge clk);
        chk("t1_d0", anode, 8'hFE);
        repeat (4) @(negedge clk);
        chk("t1_guard", anode, 8'hFF);
        repeat (2) @(negedge clk);
        chk("t1_d1", anode, 8'hFD);
        n = 0;
        while (!frame_done && n < 100) begin @(negedge clk); n++; end
        chk("t1_fd_latency", n, 42);
        chk("t1_fd_digit", digit_sel, 0);
        chk("t1_fd_anode", anode, 8'hFE);
        en = 0;
        @(negedge clk);
        // 2: load in IDLE, applied on the enable edge
        load = 1; din = 32'h8765_4321;
        @(negedge clk);
        load = 0;
        chk("t2_pend_idle", pending, 1);
        en = 1;
        @(negedge clk);
        chk("t2_pend_clr", pending, 0);
        chk("t2_nib0", nibble, 1);
        for (int i = 1; i < 8; i++) begin
            repeat (SLOT) @(negedge clk);
            chk("t2_digit", digit_sel, i);
            chk("t2_nib", nibble, i + 1);
        end
        // 3: mid-frame load held back until the frame boundary
        repeat (SLOT) @(negedge clk);
        repeat (18) @(negedge clk);
        load = 1; din = 32'hDEAD_BEEF;
        @(negedge clk);
        load = 0;
        chk("t3_pend", pending, 1);
        chk("t3_old_d3", nibble, 4);
        repeat (23) @(negedge clk);
        chk("t3_old_d7", nibble, 8);
        chk("t3_pend_hold", pending, 1);
        repeat (6) @(negedge clk);
        chk("t3_fd", frame_done, 1);
        chk("t3_new_d0", nibble, 4'hF);
        chk("t3_pend_clr", pending, 0);
        repeat (6) @(negedge clk);
        chk("t3_new_d1", nibble, 4'hE);
        // 4: load on the boundary edge overrides a pending shadow
        load = 1; din = 32'h1234_5678;
        @(negedge clk);
        load = 0;
        chk("t4_pend", pending, 1);
        repeat (40) @(negedge clk);
        load = 1; din = 32'h0000_00A5;
        @(negedge clk);
        load = 0;
        chk("t4_fd", frame_done, 1);
        chk("t4_pend_clr", pending, 0);
        chk("t4_nib0", nibble, 5);
        repeat (6) @(negedge clk);
        chk("t4_nib1", nibble, 4'hA);
        // 5: leading-zero blanking of 0x305
        load = 1; din = 32'h0000_0305; blank_lz = 1;
        @(negedge clk);
        load = 0;
        repeat (41) @(negedge clk);
        chk("t5_fd", frame_done, 1);
        chk("t5_s0", anode, 8'hFE);
        repeat (6) @(negedge clk);
        chk("t5_s1", anode, 8'hFD);
        chk("t5_s1_nib", nibble, 0);
        repeat (6) @(negedge clk);
        chk("t5_s2", anode, 8'hFB);
        repeat (6) @(negedge clk);
        chk("t5_s3", anode, 8'hFF);
        chk("t5_s3_digit", digit_sel, 3);
        // 6a: enable dropped during GUARD
        repeat (4) @(negedge clk);
        chk("t6_guard", anode, 8'hFF);
        chk("t6_guard_digit", digit_sel, 3);
        en = 0; blank_lz = 0;
        @(negedge clk);
        chk("t6_idle_anode", anode, 8'hFF);
        chk("t6_idle_digit", digit_sel, 0);
        // 6b: reset during DRIVE of digit 5
        en = 1;
        @(negedge clk);
        load = 1; din = 32'h1111_1111;
        @(negedge clk);
        load = 0;
        chk("t6_pend", pending, 1);
        repeat (29) @(negedge clk);
        chk("t6_d5_digit", digit_sel, 5);
        chk("t6_d5_anode", anode, 8'hDF);
        rst = 1; en = 0;
        @(negedge clk);
        chk("t6_rst_anode", anode, 8'hFF);
        chk("t6_rst_digit", digit_sel, 0);
        chk("t6_rst_pend", pending, 0);
        chk("t6_rst_nib", nibble, 0);
        rst = 0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
